// File: rtl/psrm_neuron_p.sv
// Purpose: fixed-point leaky integrate-and-fire neuron (synaptic current s, membrane v, INTEG/FIRE/REFRAC FSM); PSRM_SPIKE_COUNT_EN adds a saturating spike counter.
// Latency: o_spike rises one clock after the qualifying i_valid step; o_vmem/o_isyn are the state registers themselves.
// Backpressure: none; every i_valid cycle is consumed as exactly one timestep, idle cycles hold all state.
module psrm_neuron_p #(
    parameter int                  N_SYN        = 8,
    parameter int                  W            = 14,
    parameter int                  FRAC         = 8,
    parameter logic signed [W-1:0] WEIGHT_E     = 14'h800,
    parameter logic signed [W-1:0] WEIGHT_I     = 14'hF33,
    parameter logic signed [W-1:0] DS           = 14'h94,
    parameter logic signed [W-1:0] DM           = 14'h25,
    parameter logic signed [W-1:0] THRESHOLD    = 14'hC00,
    parameter int                  REFRAC_STEPS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    input  logic [N_SYN-1:0]    i_excitatory,
    input  logic [N_SYN-1:0]    i_inhibitory,
`ifdef PSRM_SPIKE_COUNT_EN
    input  logic                i_count_clr,
    output logic [15:0]         o_spike_count,
`endif
    output logic                o_spike,
    output logic signed [W-1:0] o_vmem,
    output logic signed [W-1:0] o_isyn,
    output logic                o_refrac
);

    localparam int CW = $clog2(N_SYN + 1);
    localparam int IW = W + $clog2(N_SYN) + 1;
    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 2;
    localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (W - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = SW'(-(2 ** (W - 1)));
    localparam logic [7:0] REFRAC_LOAD = 8'(REFRAC_STEPS);

    typedef enum logic [1:0] {
        INTEG  = 2'd0,
        FIRE   = 2'd1,
        REFRAC = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic signed [W-1:0]  s_q, s_d, v_q, v_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [CW-1:0]        pop_e, pop_i;
    logic signed [IW-1:0] drive;
    logic signed [PW-1:0] s_prod, v_prod;
    logic signed [W-1:0]  s_new, v_new;

    function automatic logic [CW-1:0] popcount(input logic [N_SYN-1:0] x);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < N_SYN; k++) begin
            c = c + CW'(x[k]);
        end
        return c;
    endfunction

    function automatic logic signed [W-1:0] saturate(input logic signed [SW-1:0] x);
        if (x > SAT_HI) begin
            return {1'b0, {(W-1){1'b1}}};
        end else if (x < SAT_LO) begin
            return {1'b1, {(W-1){1'b0}}};
        end else begin
            return x[W-1:0];
        end
    endfunction

    // candidate s/v for this step; v uses the pre-update s (one-step lag)
    always_comb begin
        pop_e  = popcount(i_excitatory);
        pop_i  = popcount(i_inhibitory);
        drive  = $signed(IW'(pop_e)) * IW'(WEIGHT_E) - $signed(IW'(pop_i)) * IW'(WEIGHT_I);
        s_prod = PW'(s_q) * PW'(DS);
        v_prod = PW'(v_q) * PW'(DM);
        s_new  = saturate(SW'(s_q) - SW'(s_prod >>> FRAC) + SW'(drive));
        v_new  = saturate(SW'(v_q) - SW'(v_prod >>> FRAC) + SW'(s_q));
    end

    // next state: FIRE lasts one clock regardless of i_valid, REFRAC counts valid steps only
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        case (state_q)
            INTEG: begin
                if (i_valid) begin
                    s_d = s_new;
                    if (v_new >= THRESHOLD) begin
                        state_d = FIRE;
                        v_d     = '0;
                    end else begin
                        v_d = v_new;
                    end
                end
            end
            FIRE: begin
                if (i_valid) begin
                    s_d = s_new;
                end
                v_d = '0;
                if (REFRAC_STEPS == 0) begin
                    state_d = INTEG;
                end else begin
                    state_d = REFRAC;
                    cnt_d   = REFRAC_LOAD;
                end
            end
            REFRAC: begin
                v_d = '0;
                if (i_valid) begin
                    s_d = s_new;
                    if (cnt_q <= 8'd1) begin
                        state_d = INTEG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = INTEG;
                v_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INTEG;
            s_q     <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_spike  = (state_q == FIRE);
    assign o_refrac = (state_q == REFRAC);
    assign o_vmem   = v_q;
    assign o_isyn   = s_q;

`ifdef PSRM_SPIKE_COUNT_EN
    logic        fire_entry;
    logic [15:0] spike_count_q;

    assign fire_entry = (state_q == INTEG) && (state_d == FIRE);

    // count FIRE entries, saturating; a clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spike_count_q <= '0;
        end else if (i_count_clr) begin
            spike_count_q <= '0;
        end else if (fire_entry && (spike_count_q != 16'hFFFF)) begin
            spike_count_q <= spike_count_q + 16'd1;
        end
    end

    assign o_spike_count = spike_count_q;
`endif

endmodule

// File: tb/tb_psrm_neuron_p.sv
module tb_psrm_neuron_p;

    localparam int W         = 14;
    localparam int FRAC      = 8;
    localparam int WE        = 2048;
    localparam int WI        = 3891;
    localparam int DS        = 148;
    localparam int DM        = 37;
    localparam int TH        = 3072;
    localparam int RS        = 4;
    localparam int PH_INTEG  = 0;
    localparam int PH_FIRE   = 1;
    localparam int PH_REFRAC = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                i_valid;
    logic [7:0]          i_excitatory;
    logic [7:0]          i_inhibitory;
    logic                o_spike;
    logic                o_refrac;
    logic signed [W-1:0] o_vmem;
    logic signed [W-1:0] o_isyn;
`ifdef PSRM_SPIKE_COUNT_EN
    logic                i_count_clr;
    logic [15:0]         o_spike_count;
    bit                  clr_req = 1'b0;
    int                  m_cnt;
`endif

    typedef struct {
        bit spike;
        int vmem;
        int isyn;
        bit refrac;
`ifdef PSRM_SPIKE_COUNT_EN
        int cnt;
`endif
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int m_s, m_v, m_phase, m_seen, m_fires;

    psrm_neuron_p dut (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .i_excitatory (i_excitatory),
        .i_inhibitory (i_inhibitory),
`ifdef PSRM_SPIKE_COUNT_EN
        .i_count_clr  (i_count_clr),
        .o_spike_count(o_spike_count),
`endif
        .o_spike      (o_spike),
        .o_vmem       (o_vmem),
        .o_isyn       (o_isyn),
        .o_refrac     (o_refrac)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    function automatic int clamp(input int x);
        if (x > 8191)  return 8191;
        if (x < -8192) return -8192;
        return x;
    endfunction

    function automatic int next_s(input logic [7:0] e, input logic [7:0] i);
        return clamp(m_s - ((m_s * DS) >>> FRAC) + $countones(e) * WE - $countones(i) * WI);
    endfunction

    function automatic int next_v();
        return clamp(m_v - ((m_v * DM) >>> FRAC) + m_s);
    endfunction

    function automatic bit would_fire();
        return (m_phase == PH_INTEG) && (next_v() >= TH);
    endfunction

    function automatic void model_reset();
        m_s     = 0;
        m_v     = 0;
        m_phase = PH_INTEG;
        m_seen  = 0;
`ifdef PSRM_SPIKE_COUNT_EN
        m_cnt   = 0;
`endif
    endfunction

    function automatic void model_clock(input bit vld, input logic [7:0] e, input logic [7:0] i);
        int sn, vn;
        bit entered;
        sn      = next_s(e, i);
        vn      = next_v();
        entered = 1'b0;
        if (m_phase == PH_INTEG) begin
            if (vld) begin
                m_s = sn;
                if (vn >= TH) begin
                    m_phase = PH_FIRE;
                    m_v     = 0;
                    entered = 1'b1;
                end else begin
                    m_v = vn;
                end
            end
        end else if (m_phase == PH_FIRE) begin
            if (vld) m_s = sn;
            m_v     = 0;
            m_seen  = 0;
            m_phase = (RS == 0) ? PH_INTEG : PH_REFRAC;
        end else begin
            if (vld) begin
                m_s = sn;
                m_seen++;
                if (m_seen >= RS) begin
                    m_phase = PH_INTEG;
                    m_seen  = 0;
                end
            end
        end
        if (entered) m_fires++;
`ifdef PSRM_SPIKE_COUNT_EN
        if (clr_req) m_cnt = 0;
        else if (entered && m_cnt < 65535) m_cnt++;
`endif
    endfunction

    task automatic do_cycle(input bit vld, input logic [7:0] e, input logic [7:0] i);
        exp_t x;
        @(negedge clk);
        i_valid      = vld;
        i_excitatory = e;
        i_inhibitory = i;
`ifdef PSRM_SPIKE_COUNT_EN
        i_count_clr  = clr_req;
`endif
        model_clock(vld, e, i);
        x.spike  = (m_phase == PH_FIRE);
        x.vmem   = m_v;
        x.isyn   = m_s;
        x.refrac = (m_phase == PH_REFRAC);
`ifdef PSRM_SPIKE_COUNT_EN
        x.cnt    = m_cnt;
`endif
        exp_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        i_valid      = 1'b0;
        i_excitatory = '0;
        i_inhibitory = '0;
`ifdef PSRM_SPIKE_COUNT_EN
        i_count_clr  = 1'b0;
`endif
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // monitor: compares every registered output set against the queued prediction
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("sb_spike", int'(o_spike), int'(x.spike));
                chk("sb_vmem", o_vmem, x.vmem);
                chk("sb_isyn", o_isyn, x.isyn);
                chk("sb_refrac", int'(o_refrac), int'(x.refrac));
`ifdef PSRM_SPIKE_COUNT_EN
                chk("sb_count", int'(o_spike_count), x.cnt);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        int dut_spikes;
        int fire_base;
        reset        = 1'b0;
        i_valid      = 1'b0;
        i_excitatory = '0;
        i_inhibitory = '0;
`ifdef PSRM_SPIKE_COUNT_EN
        i_count_clr  = 1'b0;
`endif
        model_reset();
        m_fires = 0;
        #1;
        chk("rst_spike", int'(o_spike), 0);
        chk("rst_vmem", o_vmem, 0);
        chk("rst_isyn", o_isyn, 0);
        chk("rst_refrac", int'(o_refrac), 0);
`ifdef PSRM_SPIKE_COUNT_EN
        chk("rst_count", int'(o_spike_count), 0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // single-step response and hold
        do_cycle(1'b1, 8'h01, 8'h00);
        chk("step1_isyn", o_isyn, 14'sh0800);
        chk("step1_vmem", o_vmem, 0);
        do_cycle(1'b1, 8'h00, 8'h00);
        chk("step2_isyn", o_isyn, 14'sh0360);
        chk("step2_vmem", o_vmem, 14'sh0800);
        for (int k = 0; k < 20; k++) do_cycle(1'b0, 8'hFF, 8'h5A);
        chk("hold_isyn", o_isyn, 14'sh0360);
        chk("hold_vmem", o_vmem, 14'sh0800);
        chk("hold_refrac", int'(o_refrac), 0);
        chk("hold_spike", int'(o_spike), 0);

        // saturation both ways
        apply_reset();
        do_cycle(1'b1, 8'hFF, 8'h00);
        chk("sat_pos_isyn", o_isyn, 14'sh1FFF);
        apply_reset();
        do_cycle(1'b1, 8'h00, 8'hFF);
        chk("sat_neg_isyn", o_isyn, 14'sh2000);

        // fire and refractory under constant drive
        apply_reset();
        run        = 0;
        dut_spikes = 0;
        fire_base  = m_fires;
        for (int k = 0; k < 40; k++) begin
            do_cycle(1'b1, 8'h03, 8'h00);
            chk("spike_vs_refrac", int'(o_spike & o_refrac), 0);
            if (o_spike) begin
                dut_spikes++;
                chk("fire_vmem_zero", o_vmem, 0);
            end
            if (o_refrac) begin
                run++;
            end else if (run != 0) begin
                chk("refrac_len", run, RS);
                run = 0;
            end
        end
        chk("fire_count", dut_spikes, m_fires - fire_base);

        // asynchronous reset during refractory
        apply_reset();
        for (int k = 0; k < 3; k++) do_cycle(1'b1, 8'h03, 8'h00);
        chk("pre_rst_refrac", int'(o_refrac), 1);
        @(negedge clk);
        i_valid = 1'b0;
        reset   = 1'b0;
        #1;
        chk("arst_refrac", int'(o_refrac), 0);
        chk("arst_vmem", o_vmem, 0);
        chk("arst_isyn", o_isyn, 0);
        chk("arst_spike", int'(o_spike), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("post_rst_spike", int'(o_spike), 0);
        chk("post_rst_refrac", int'(o_refrac), 0);
        do_cycle(1'b1, 8'h01, 8'h00);
        chk("resume_isyn", o_isyn, 14'sh0800);

        // randomized traffic with occasional resets
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 99) == 0) apply_reset();
            do_cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom) & 8'($urandom));
        end

`ifdef PSRM_SPIKE_COUNT_EN
        // spike counter: three fires, then a clear coinciding with a FIRE entry
        apply_reset();
        m_fires = 0;
        for (int k = 0; k < 60 && m_fires < 3; k++) do_cycle(1'b1, 8'h03, 8'h00);
        chk("count_three", int'(o_spike_count), 3);
        for (int k = 0; k < 20; k++) begin
            if (would_fire()) begin
                clr_req = 1'b1;
                do_cycle(1'b1, 8'h03, 8'h00);
                clr_req = 1'b0;
                chk("count_clr_on_fire", int'(o_spike_count), 0);
                chk("spike_on_clr", int'(o_spike), 1);
                break;
            end
            do_cycle(1'b1, 8'h03, 8'h00);
        end
        do_cycle(1'b0, 8'h00, 8'h00);
`endif

        @(posedge clk);
        #3;
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
